// File: rtl/fetch_pkg.sv
// Shared types and constants for the program-counter fetch stage.
package fetch_pkg;

  // Fetch controller states.
  typedef enum logic [1:0] {
    RUN   = 2'b00,
    FAULT = 2'b01
  } fetch_state_t;

  // Encodings reported on fault_cause.
  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_RANGE    = 2'b01;
  localparam logic [1:0] FAULT_MISALIGN = 2'b10;

  // Byte distance between consecutive instruction words.
  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-to-decode instruction handshake (valid/ready with instruction and its PC).
interface pc_fetch_unit_if #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
);

  logic                   instr_valid;
  logic                   instr_ready;
  logic [INSTR_WIDTH-1:0] instr;
  logic [PC_WIDTH-1:0]    instr_pc;

  // Fetch side produces instructions.
  modport master (
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  // Decode side consumes instructions.
  modport slave (
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/pc_rom_index.sv
// Converts a byte PC into a ROM word index and flags range / alignment problems.
module pc_rom_index #(
  parameter int                  PC_WIDTH   = 32,
  parameter int                  ADDR_WIDTH = 5,
  parameter logic [PC_WIDTH-1:0] ROM_BASE   = '0
) (
  input  logic [PC_WIDTH-1:0]   pc,
  output logic [ADDR_WIDTH-1:0] idx,
  output logic                  in_range,
  output logic                  misaligned
);

  logic [PC_WIDTH-1:0] offset;

  // Offset from the ROM base; a single 2-bit shift turns bytes into words, and
  // the bytes-in-ROM limit is tested by checking everything above the index bits.
  always_comb begin
    offset     = pc - ROM_BASE;
    idx        = ADDR_WIDTH'(offset >> 2);
    in_range   = (pc >= ROM_BASE) && ((offset >> (ADDR_WIDTH + 2)) == '0);
    misaligned = (pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter fetch stage: owns the PC, drives a synchronous-read ROM and
// hands instructions to decode over valid/ready, halting on fetch faults.
// Optional build macro PC_MISALIGN_CHECK_EN adds a misaligned-PC fault.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  ADDR_WIDTH  = 5,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [PC_WIDTH-1:0] ROM_BASE    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   rom_en,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [INSTR_WIDTH-1:0] rom_data,
  pc_fetch_unit_if.master        dec,
  output logic                   fault,
  output logic [1:0]             fault_cause,
  output logic [PC_WIDTH-1:0]    fault_pc
);

  fetch_state_t        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                inflight_q, inflight_d;
  logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                fault_q, fault_d;
  logic [1:0]          fault_cause_q, fault_cause_d;
  logic [PC_WIDTH-1:0] fault_pc_q, fault_pc_d;

  logic                pc_in_range;
  logic                pc_misaligned;
  logic                slot_free;
  logic                check_en;
  logic                misalign_flt;
  logic                range_flt;
  logic                issue;

  pc_rom_index #(
    .PC_WIDTH   (PC_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ROM_BASE   (ROM_BASE)
  ) u_index (
    .pc         (pc_q),
    .idx        (rom_addr),
    .in_range   (pc_in_range),
    .misaligned (pc_misaligned)
  );

`ifndef PC_MISALIGN_CHECK_EN
  // Low PC bits play no part in fetch decisions in this build.
  logic unused_misaligned;
  assign unused_misaligned = pc_misaligned;
`endif

  // Decide whether this cycle issues a ROM read or raises a fault.
  always_comb begin
    slot_free = !inflight_q || dec.instr_ready;
    check_en  = (state_q == RUN) && !redirect_valid && slot_free;
`ifdef PC_MISALIGN_CHECK_EN
    misalign_flt = check_en && pc_misaligned;
`else
    misalign_flt = 1'b0;
`endif
    range_flt = check_en && !misalign_flt && !pc_in_range;
    issue     = check_en && !misalign_flt && pc_in_range;
  end

  // Next-state: redirect wins; otherwise drain/accept, issue, or fault.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    fault_d       = fault_q;
    fault_cause_d = fault_cause_q;
    fault_pc_d    = fault_pc_q;
    if (redirect_valid) begin
      pc_d          = redirect_pc;
      inflight_d    = 1'b0;
      state_d       = RUN;
      fault_d       = 1'b0;
      fault_cause_d = FAULT_NONE;
    end else begin
      if (inflight_q && dec.instr_ready) begin
        inflight_d = 1'b0;
      end
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + PC_WIDTH'(PC_STEP);
      end
      if (misalign_flt || range_flt) begin
        state_d       = FAULT;
        fault_d       = 1'b1;
        fault_cause_d = misalign_flt ? FAULT_MISALIGN : FAULT_RANGE;
        fault_pc_d    = pc_q;
      end
    end
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fault_q       <= 1'b0;
      fault_cause_q <= FAULT_NONE;
      fault_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fault_q       <= fault_d;
      fault_cause_q <= fault_cause_d;
      fault_pc_q    <= fault_pc_d;
    end
  end

  // The ROM is never enabled while reset is asserted.
  assign rom_en = issue && rst_n;

  assign dec.instr_valid = inflight_q;
  assign dec.instr       = rom_data;
  assign dec.instr_pc    = inflight_pc_q;

  assign fault       = fault_q;
  assign fault_cause = fault_cause_q;
  assign fault_pc    = fault_pc_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Parametrised program-counter fetch stage that replaces the fixed 32-bit-PC / 5-bit-index converter.
- Owns the PC register and sequential increment, and handles branch/jump redirect.
- Converts PC to a ROM word index and drives a synchronous-read instruction ROM.
- Presents fetched instructions to decode over a valid/ready handshake, with range-fault detection.
- Sits between the branch/jump resolution logic and the decode stage.

Parameters:
- PC_WIDTH, 32, PC and redirect target width in bits.
- ADDR_WIDTH, 5, ROM word-index width; ROM depth = 2**ADDR_WIDTH words.
- INSTR_WIDTH, 32, ROM data / instruction width.
- RESET_PC, 0, PC value loaded on reset.
- ROM_BASE, 0, byte address of ROM word 0; must be a multiple of 4.

Ports:
- clk  input  1  Rising-edge clock; the only clock.
- rst_n  input  1  Synchronous, active-low reset, sampled on the clk rising edge.
- redirect_valid  input  1  Load redirect_pc into the PC this cycle.
- redirect_pc  input  PC_WIDTH  Redirect target byte address.
- rom_en  output  1  ROM read enable; when low, the ROM holds its previous rom_data.
- rom_addr  output  ADDR_WIDTH  ROM word index.
- rom_data  input  INSTR_WIDTH  ROM read data, valid 1 cycle after an enabled read.
- instr_valid  output  1  instr and instr_pc are valid.
- instr_ready  input  1  Decode accepts the instruction.
- instr  output  INSTR_WIDTH  Fetched instruction.
- instr_pc  output  PC_WIDTH  Byte address of instr.
- fault  output  1  Fetch halted on a fault.
- fault_cause  output  2  01 = out of range, 10 = misaligned, 00 = none.
- fault_pc  output  PC_WIDTH  PC that caused the fault.

Behaviour:
- Index: idx = (pc_q - ROM_BASE) >> 2, truncated to ADDR_WIDTH; exactly one 2-bit shift.
- In range iff pc_q >= ROM_BASE and (pc_q - ROM_BASE) < 4 * 2**ADDR_WIDTH.
- rom_addr = idx(pc_q) combinationally.
- States: RUN, FAULT (2-bit encoding from the package).
- Reset (rst_n low at a clk edge) gives:
  - pc_q = RESET_PC, state = RUN, inflight = 0, inflight_pc = 0.
  - fault = 0, fault_cause = 00, fault_pc = 0.
  - rom_en = 0 during reset.
- Reset mid-operation drops any in-flight instruction; there is no handshake completion.
- issue = state==RUN & !redirect_valid & in_range & (!inflight | instr_ready).
- On issue:
  - rom_en = 1.
  - inflight <= 1; inflight_pc <= pc_q.
  - pc_q <= pc_q + 4, wrapping modulo 2**PC_WIDTH.
- Latency: instruction at index idx(pc_q) appears on instr one cycle after issue.
- Outputs: instr_valid = inflight; instr = rom_data; instr_pc = inflight_pc.
- Stall: instr_valid & !instr_ready.
  - rom_en = 0, pc_q held, instr/instr_pc stable until accepted.
- Transfer on instr_valid & instr_ready:
  - With a same-cycle issue, back-to-back output; throughput is 1 instruction per cycle.
  - Without one, inflight <= 0.
- Redirect (redirect_valid high):
  - pc_q <= redirect_pc; inflight <= 0, squashing the output on the next cycle.
  - state <= RUN; fault <= 0; fault_cause <= 00.
  - No issue that cycle; the first fetch from the target is issued the next cycle.
  - A transfer (instr_valid & instr_ready) in the redirect cycle is still counted as taken by decode.
  - Redirect has priority over fault detection and issue.
- Range fault:
  - Trigger: state==RUN, !redirect_valid, !in_range, and the output slot is free (!inflight | instr_ready).
  - Action: state <= FAULT, fault <= 1, fault_cause <= 01, fault_pc <= pc_q.
  - Nothing is issued; any pending instruction drains normally first.
- FAULT state: no issue, outputs held; exit only by redirect or reset.
- Wrap: PC wrapping past 2**PC_WIDTH-1 is legal; the wrapped PC is then range-checked.

Optional Feature:
- Macro: PC_MISALIGN_CHECK_EN.
- Defined:
  - Misalignment (pc_q[1:0] != 00) is checked under the same conditions as range.
  - It takes priority over the range check.
  - Response: FAULT state, fault_cause = 10, fault_pc = pc_q.
  - Misaligned redirect targets fault on the next cycle.
- Undefined:
  - pc_q[1:0] is ignored for indexing and checking, and fault_cause 10 never occurs.
  - redirect_pc[1:0] is still loaded as given.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t (RUN, FAULT).
  - FAULT_NONE / FAULT_RANGE / FAULT_MISALIGN 2-bit constants.
  - PC_STEP = 4.
- Sub-module pc_rom_index (combinational):
  - Parameters PC_WIDTH, ADDR_WIDTH, ROM_BASE.
  - Inputs pc; outputs idx, in_range, misaligned.
  - Instantiated once on pc_q.

Test Plan:
- Reset, then instr_ready=1 for 8 cycles (RESET_PC=0): rom_addr 0,1,...,7 on consecutive cycles; instr_pc 0,4,...,28 one cycle later; instr_valid continuous from the 2nd cycle.
- Drop instr_ready while instr_pc=0x8 for 3 cycles: instr/instr_pc held at 0x8, rom_en=0, pc_q=0xC; resume → 0xC is the next transfer, with no duplicate or skip.
- redirect_valid with redirect_pc=0x40 while instr_pc=0x10 is valid and not ready: next cycle instr_valid=0; the following cycle rom_addr=16; then instr_pc=0x40.
- Default params, run sequentially: the fetch at PC 0x7C completes; at pc_q=0x80, fault=1, fault_cause=01, fault_pc=0x80, no further rom_en; redirect to 0x0 clears the fault and fetch restarts.
- Assert rst_n=0 mid-stall with instr_valid=1: next edge gives instr_valid=0, fault=0, pc_q=RESET_PC; fetch restarts after rst_n returns high.
- With PC_MISALIGN_CHECK_EN, redirect to 0x6: fault_cause=10, fault_pc=0x6. Without the macro, the same stimulus fetches index 1 with instr_pc=0x6.
